// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit queue.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        TXQ_IDLE      = 2'd0,
        TXQ_ISSUE     = 2'd1,
        TXQ_WAIT_BUSY = 2'd2,
        TXQ_WAIT_DONE = 2'd3
    } txq_state_e;

endpackage

// File: rtl/uart_txq_fifo.sv
// Circular byte buffer with wrapping pointers and a separate level counter.
module uart_txq_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en_i,
    input  logic [UART_DATA_W-1:0] wr_data_i,
    input  logic                   rd_en_i,
    output logic [UART_DATA_W-1:0] rd_data_o,
    output logic [AW:0]            level_o,
    output logic                   empty_o,
    output logic                   full_o
);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic          push, pop;

    assign full_o    = (level_q == (AW+1)'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rd_data_o = mem_q[rptr_q];

    assign push = wr_en_i && !full_o;
    assign pop  = rd_en_i && !empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);
        if (push && !pop)      level_d = level_q + (AW+1)'(1);
        else if (pop && !push) level_d = level_q - (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding a UART transmitter using tx_busy as flow control.
// Optional drop counter: define UART_TXQ_DROP_CNT_EN.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AW        = $clog2(DEPTH),
    parameter int BUSY_WAIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_DATA_W-1:0] push_data,
    input  logic                   push_valid,
    output logic                   push_ready,
    output logic [UART_DATA_W-1:0] uart_din,
    output logic                   uart_wr_en,
    input  logic                   uart_tx_busy,
    output logic [AW:0]            level,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow,
    input  logic                   ovf_clr
`ifdef UART_TXQ_DROP_CNT_EN
    ,
    output logic [15:0]            drop_cnt
`endif
);

    localparam int TW = $clog2(BUSY_WAIT + 1);

    txq_state_e             state_q, state_d;
    logic [UART_DATA_W-1:0] din_q, din_d;
    logic                   wr_en_q, wr_en_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   ovf_q, ovf_d;
    logic                   pop;
    logic                   refused;
    logic [UART_DATA_W-1:0] head;

    uart_txq_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (push_valid),
        .wr_data_i (push_data),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .level_o   (level),
        .empty_o   (empty),
        .full_o    (full)
    );

    assign push_ready = !full;
    assign refused    = push_valid && full;
    assign uart_din   = din_q;
    assign uart_wr_en = wr_en_q;
    assign overflow   = ovf_q;

    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        wr_en_d = 1'b0;
        tmo_d   = tmo_q;
        pop     = 1'b0;
        unique case (state_q)
            TXQ_IDLE: begin
                if (!empty && !uart_tx_busy) begin
                    state_d = TXQ_ISSUE;
                    din_d   = head;
                    wr_en_d = 1'b1;
                    pop     = 1'b1;
                end
            end
            TXQ_ISSUE: begin
                state_d = TXQ_WAIT_BUSY;
                tmo_d   = '0;
            end
            TXQ_WAIT_BUSY: begin
                // A transmitter that never raises busy still counts as sent.
                if (uart_tx_busy)
                    state_d = TXQ_WAIT_DONE;
                else if (tmo_q == TW'(BUSY_WAIT - 1))
                    state_d = TXQ_IDLE;
                else
                    tmo_d = tmo_q + TW'(1);
            end
            TXQ_WAIT_DONE: begin
                if (!uart_tx_busy) state_d = TXQ_IDLE;
            end
            default: state_d = TXQ_IDLE;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr)      ovf_d = 1'b0;
        else if (refused) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TXQ_IDLE;
            din_q   <= '0;
            wr_en_q <= 1'b0;
            tmo_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            wr_en_q <= wr_en_d;
            tmo_q   <= tmo_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef UART_TXQ_DROP_CNT_EN
    logic [15:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (ovf_clr)
            drop_d = '0;
        else if (refused && drop_q != 16'hFFFF)
            drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_q <= '0;
        else     drop_q <= drop_d;
    end

    assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue with a behavioural tx_busy model.
module tb_uart_tx_queue;

    localparam int DEPTH     = 16;
    localparam int AW        = $clog2(DEPTH);
    localparam int BUSY_WAIT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    push_data = '0;
    logic          push_valid = 1'b0;
    logic          push_ready;
    logic [7:0]    uart_din;
    logic          uart_wr_en;
    logic          busy;
    logic [AW:0]   level;
    logic          empty, full, overflow;
    logic          ovf_clr = 1'b0;
`ifdef UART_TXQ_DROP_CNT_EN
    logic [15:0]   drop_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_strobe = 0;
    int last_strobe = 0;
    int prev_strobe = 0;
    logic [7:0] sb [$];

    bit busy_hold  = 1'b0;
    bit never_busy = 1'b0;
    int busy_len   = 3;
    int busy_cnt;

    uart_tx_queue #(
        .DEPTH     (DEPTH),
        .BUSY_WAIT (BUSY_WAIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .push_data    (push_data),
        .push_valid   (push_valid),
        .push_ready   (push_ready),
        .uart_din     (uart_din),
        .uart_wr_en   (uart_wr_en),
        .uart_tx_busy (busy),
        .level        (level),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow),
        .ovf_clr      (ovf_clr)
`ifdef UART_TXQ_DROP_CNT_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter stand-in: busy rises the cycle after a strobe.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            busy_cnt <= 0;
        end else if (busy_hold) begin
            busy <= 1'b1;
        end else if (uart_wr_en && !never_busy) begin
            busy     <= 1'b1;
            busy_cnt <= busy_len;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            busy     <= 1'b0;
            busy_cnt <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe pops the scoreboard.
    logic prev_wr = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (uart_wr_en) begin
                chk("strobe_back_to_back", {31'd0, prev_wr}, 32'd0);
                chk("strobe_while_busy", {31'd0, busy}, 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", {24'd0, uart_din}, 32'hFFFF_FFFF);
                end else begin
                    chk("tx_byte", {24'd0, uart_din}, {24'd0, sb.pop_front()});
                end
                prev_strobe = last_strobe;
                last_strobe = cyc;
                n_strobe++;
            end
            prev_wr = uart_wr_en;
        end else begin
            prev_wr = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input bit acc);
        push_data  = b;
        push_valid = 1'b1;
        if (acc) sb.push_back(b);
        tick();
        push_valid = 1'b0;
    endtask

    task automatic push_fc(input logic [7:0] b);
        int n;
        n = 0;
        while (!push_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("push_ready_timeout", 32'd0, 32'd1);
        push(b, 1'b1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) chk({name, "_drain_timeout"}, sb.size(), 32'd0);
        repeat (30) tick();
        chk({name, "_level0"}, {27'd0, level}, 32'd0);
        chk({name, "_empty"}, {31'd0, empty}, 32'd1);
    endtask

    initial begin
        int s;
        #12;
        rst = 1'b0;
        #1;
        tick();

        chk("rst_level", {27'd0, level}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_push_ready", {31'd0, push_ready}, 32'd1);
        chk("rst_din", {24'd0, uart_din}, 32'd0);
        chk("rst_wr_en", {31'd0, uart_wr_en}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
`ifdef UART_TXQ_DROP_CNT_EN
        chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
`endif

        // Single byte latency
        busy_len = 4;
        push(8'hA5, 1'b1);
        chk("single_level_e0", {27'd0, level}, 32'd1);
        chk("single_wr_e0", {31'd0, uart_wr_en}, 32'd0);
        tick();
        chk("single_wr_e1", {31'd0, uart_wr_en}, 32'd1);
        chk("single_din_e1", {24'd0, uart_din}, 32'hA5);
        chk("single_level_e1", {27'd0, level}, 32'd0);
        tick();
        chk("single_wr_e2", {31'd0, uart_wr_en}, 32'd0);
        chk("single_din_hold", {24'd0, uart_din}, 32'hA5);
        drain("single");

        // Burst order
        busy_len = 5;
        s = n_strobe;
        push(8'hA5, 1'b1);
        push(8'hFF, 1'b1);
        push(8'h00, 1'b1);
        chk("burst_level_peak", {27'd0, level}, 32'd2);
        drain("burst");
        chk("burst_strobes", n_strobe - s, 32'd3);

        // Fill and overflow
        busy_hold = 1'b1;
        tick();
        for (int i = 0; i < DEPTH + 2; i++)
            push(8'h10 + 8'(i), i < DEPTH);
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_push_ready", {31'd0, push_ready}, 32'd0);
        chk("fill_level", {27'd0, level}, DEPTH);
        chk("fill_overflow", {31'd0, overflow}, 32'd1);
`ifdef UART_TXQ_DROP_CNT_EN
        chk("fill_drop_cnt", {16'd0, drop_cnt}, 32'd2);
`endif
        ovf_clr = 1'b1;
        push(8'hEE, 1'b0);
        ovf_clr = 1'b0;
        chk("clr_overflow", {31'd0, overflow}, 32'd0);
        chk("clr_level", {27'd0, level}, DEPTH);
`ifdef UART_TXQ_DROP_CNT_EN
        chk("clr_drop_cnt", {16'd0, drop_cnt}, 32'd0);
`endif
        busy_hold = 1'b0;
        busy_len  = 3;
        drain("fill");

        // Wrap-around
        busy_len = 2;
        s = n_strobe;
        for (int i = 0; i < 3 * DEPTH; i++)
            push_fc(8'(i));
        drain("wrap");
        chk("wrap_strobes", n_strobe - s, 3 * DEPTH);
        chk("wrap_overflow", {31'd0, overflow}, 32'd0);

        // Busy never rises: timeout path
        never_busy = 1'b1;
        push(8'hB1, 1'b1);
        push(8'hB2, 1'b1);
        drain("timeout");
        chk("timeout_spacing", last_strobe - prev_strobe, 2 + BUSY_WAIT);
        never_busy = 1'b0;

        // Reset during WAIT_DONE with five bytes queued
        busy_len = 20;
        for (int i = 0; i < 6; i++)
            push(8'hC0 + 8'(i), 1'b1);
        chk("rstmid_level", {27'd0, level}, 32'd5);
        chk("rstmid_busy", {31'd0, busy}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("rstmid_level0", {27'd0, level}, 32'd0);
        chk("rstmid_empty", {31'd0, empty}, 32'd1);
        chk("rstmid_full", {31'd0, full}, 32'd0);
        chk("rstmid_ready", {31'd0, push_ready}, 32'd1);
        chk("rstmid_din", {24'd0, uart_din}, 32'd0);
        chk("rstmid_wr_en", {31'd0, uart_wr_en}, 32'd0);
        chk("rstmid_overflow", {31'd0, overflow}, 32'd0);
        sb.delete();
        s = n_strobe;
        tick();
        rst = 1'b0;
        repeat (60) tick();
        chk("rstmid_no_strobe", n_strobe - s, 32'd0);
        chk("rstmid_level_after", {27'd0, level}, 32'd0);
        chk("sb_empty_end", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
